mmio_uart_tx: RTL

Memory-mapped UART transmitter on the single-cycle CPU's data port. It decodes the CPU's data address, write-data and byte-enable signals, buffers written bytes in a small FIFO, and serialises them on a TX pin. It returns status and divisor reads combinationally on the same cycle, as the CPU's load path requires. It sits beside data RAM behind the data-bus read mux; its read data is zero when the access is not addressed to it.

---
 rtl/uart_tx_pkg.sv | 25 ++
 rtl/mmio_uart_tx_if.sv | 14 +
 rtl/uart_tx_fifo.sv | 61 ++++++
 rtl/mmio_uart_tx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the memory-mapped UART transmitter.
//   - Register offsets within the 16-byte window (selected by daddr[3:2]).
//   - STATUS register bit positions.
//   - Transmit FSM state encoding.
package uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int STS_FULL  = 0;
    localparam int STS_EMPTY = 1;
    localparam int STS_BUSY  = 2;
    localparam int STS_OVF   = 3;
    localparam int STS_PAR   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU data-port bundle seen by the UART transmitter.
//   daddr  : byte address (master -> slave)
//   dwdata : lane-replicated store data (master -> slave)
//   dwe    : byte write enables (master -> slave)
//   drdata : combinational read data (slave -> master)
interface mmio_uart_tx_if;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;

    modport master (output daddr, output dwdata, output dwe, input drdata);
    modport slave  (input daddr, input dwdata, input dwe, output drdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO holding bytes waiting to be transmitted.
//   clk, reset_n : clock and asynchronous active-low reset
//   i_push/i_din : write request and data (ignored when full)
//   i_pop        : read request (ignored when empty)
//   o_dout       : head entry, valid whenever o_empty is low
//   o_full/o_empty/o_count : occupancy, all derived from the pre-edge count
// DEPTH must be a power of two so the pointers wrap on their own.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    // Head is read asynchronously so the FSM can load it on the pop edge.
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter on the CPU data port.
//   clk, reset_n : clock and asynchronous active-low reset
//   bus (slave)  : daddr/dwdata/dwe in, combinational drdata out
//   txd          : serial output, idles high
//   tx_irq       : high while the FIFO is empty and the FSM is idle
// Registers: 0x0 TXDATA (W), 0x4 STATUS, 0x8 DIV (RW), 0xC reserved.
// Optional build macro UART_TX_PARITY_EN adds an even-parity bit per frame.
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic            clk,
    input  logic            reset_n,
    mmio_uart_tx_if.slave   bus,
    output logic            txd,
    output logic            tx_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          w_hit, w_wr, w_push, w_clr_ovf, w_pop, w_bit_end;
    logic [1:0]    w_sel;
    logic          w_full, w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;
    logic          w_unused;

    tx_state_e     r_state, state_next;
    logic [15:0]   r_div;
    logic          r_ovf;
    logic [7:0]    r_shift, shift_next;
    logic [2:0]    r_bit_idx, bit_idx_next;
    logic [15:0]   r_baud_cnt, baud_next;
    logic [15:0]   r_bit_div, bit_div_next;
`ifdef UART_TX_PARITY_EN
    logic          r_parity, parity_next;
`endif

    assign w_hit     = (bus.daddr[31:4] == BASE_ADDR[31:4]);
    assign w_sel     = bus.daddr[3:2];
    assign w_wr      = w_hit && (bus.dwe != 4'b0000);
    assign w_push    = w_wr && (w_sel == REG_TXDATA) && bus.dwe[0];
    assign w_clr_ovf = w_wr && (w_sel == REG_STATUS) && bus.dwe[0] && bus.dwdata[3];
    assign w_unused  = ^{bus.dwdata[31:16], bus.daddr[1:0]};

    // The period is latched per bit so a DIV write only affects the next bit.
    assign w_bit_end = (r_baud_cnt == r_bit_div);
    assign tx_irq    = w_empty && (r_state == ST_IDLE);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_din   (bus.dwdata[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        bus.drdata = '0;
        if (w_hit) begin
            case (w_sel)
                REG_STATUS: begin
                    bus.drdata[STS_FULL]  = w_full;
                    bus.drdata[STS_EMPTY] = w_empty;
                    bus.drdata[STS_BUSY]  = (r_state != ST_IDLE);
                    bus.drdata[STS_OVF]   = r_ovf;
`ifdef UART_TX_PARITY_EN
                    bus.drdata[STS_PAR]   = 1'b1;
`endif
                    bus.drdata[15:8]      = 8'(w_count);
                end
                REG_DIV: bus.drdata[15:0] = r_div;
                default: bus.drdata = '0;
            endcase
        end
    end

    always_comb begin
        state_next   = r_state;
        shift_next   = r_shift;
        bit_idx_next = r_bit_idx;
        baud_next    = r_baud_cnt + 16'd1;
        bit_div_next = r_bit_div;
`ifdef UART_TX_PARITY_EN
        parity_next  = r_parity;
`endif
        w_pop        = 1'b0;
        txd          = 1'b1;
        // Any bit boundary restarts the baud counter with the current DIV.
        if (w_bit_end || r_state == ST_IDLE) begin
            baud_next    = '0;
            bit_div_next = r_div;
        end
        case (r_state)
            ST_IDLE, ST_STOP: begin
                if (r_state == ST_IDLE || w_bit_end) begin
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        shift_next = w_head;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^w_head;
`endif
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_START: begin
                txd = 1'b0;
                if (w_bit_end) begin
                    state_next   = ST_DATA;
                    bit_idx_next = '0;
                end
            end
            ST_DATA: begin
                txd = r_shift[0];
                if (w_bit_end) begin
                    shift_next   = {1'b0, r_shift[7:1]};
                    bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                txd = r_parity;
                if (w_bit_end) state_next = ST_STOP;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_bit_div  <= DEFAULT_DIV;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= state_next;
            r_shift    <= shift_next;
            r_bit_idx  <= bit_idx_next;
            r_baud_cnt <= baud_next;
            r_bit_div  <= bit_div_next;
`ifdef UART_TX_PARITY_EN
            r_parity   <= parity_next;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= DEFAULT_DIV;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr && w_sel == REG_DIV) begin
                if (bus.dwe[0]) r_div[7:0]  <= bus.dwdata[7:0];
                if (bus.dwe[1]) r_div[15:8] <= bus.dwdata[15:8];
            end
            if (w_push && w_full)   r_ovf <= 1'b1;
            else if (w_clr_ovf)     r_ovf <= 1'b0;
        end
    end
endmodule
